hhmmss_counter: RTL
===================

Name: hhmmss_counter

Overview:
Time-of-day counter that produces the hr/min/sec buses consumed by the calendar date block (mmdd), plus BCD display digits and a day-rollover pulse. It advances one second per enb tick. It is user-settable through the shared 4-button bank when sw1=1 (time-adjust mode), while the date block owns the buttons when sw1=0. It sits between the 1 Hz tick generator and both the date block and the display mux.

Parameters:
RST_HR, 0, hour loaded on reset (0..23)
RST_MIN, 0, minute loaded on reset (0..59)
RST_SEC, 0, second loaded on reset (0..59)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enb  in  1  one-cycle-wide 1 Hz tick, synchronous to clk
sw1  in  1  mode switch; 1 = time-adjust buttons active
btn  in  4  raw debounced button levels
hr  out  6  binary hour 0..23
min  out  6  binary minute 0..59
sec  out  6  binary second 0..59
hh1, hh2  out  4 each  hour BCD tens/ones
mi1, mi2  out  4 each  minute BCD tens/ones
ss1, ss2  out  4 each  second BCD tens/ones
day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover
running  out  1  1 = RUN state, 0 = STOP state

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: hr/min/sec = RST_HR/RST_MIN/RST_SEC, day_tick = 0, state = RUN (running = 1), edge-detector history = 0.
- Button edges: each btn[i] passes through an edgeDetector that emits a 1-cycle pulse on the rising edge. An action occurs the cycle after the press is seen.
- A button action applies only when sw1 = 1 and btn_edge is exactly one-hot. Non-one-hot edge patterns are ignored. Any edge while sw1 = 0 is ignored.
- Button actions:
  - btn0: min+1, wrapping 59 -> 0, with no carry into hr.
  - btn1: hr+1, wrapping 23 -> 0.
  - btn2: sec <= 0.
  - btn3: toggle RUN <-> STOP.
- State machine: two states, RUN and STOP. In STOP, enb is ignored; button actions still apply.
- Counting in RUN, on a cycle with enb = 1 and no valid button action:
  - sec+1.
  - At sec = 59: sec <= 0 and min+1.
  - At min = 59 with that carry: min <= 0 and hr+1.
  - At hr = 23 with that carry: hr <= 0.
- Priority, highest first: rst_n, valid button action, enb tick. If a valid button action and enb coincide, the tick is dropped (the clock loses one second). This is accepted behaviour.
- day_tick: registered. It is high for exactly the one cycle following the clock edge that moved 23:59:59 -> 00:00:00. It is never asserted by button wraps (btn1 23 -> 0 does not pulse).
- Interface contract with mmdd: on the cycle enb = 1 at 23:59:59, hr/min/sec still read 23/59/59. The date block's comparison therefore sees the rollover condition in that cycle.
- hr/min/sec are registered outputs. BCD digits are combinational from the registers: tens = value/10, ones = value%10, each 4 bits, valid in the same cycle.
- Out-of-range values (e.g. a bad parameter) are treated as the wrap point on the next increment: any value >= the limit goes to 0.
- Reset asserted mid-count takes effect immediately (asynchronous). No tick is remembered across reset.

Decomposition:
- Shared package holds the constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23, the 6-bit time-field width, and the RUN/STOP state encoding. The date block uses the same package.
- Reuse the existing edgeDetector as the only sub-module, instantiated once per button in a generate loop.
- Binary-to-BCD split is inline arithmetic, not a separate module.

Test Plan:
- Reset with RST_HR=0, RST_MIN=0, RST_SEC=0 -> outputs 00:00:00, running=1, day_tick=0. Apply 61 enb pulses -> 00:01:01, ss1=0, ss2=1.
- Preload 23:59:58 via buttons, then 2 enb pulses -> 23:59:59, then 00:00:00. day_tick is high for exactly 1 cycle after the second pulse, hh1=hh2=0.
- sw1=1, press btn1 24 times from hr=5 -> hr=5. day_tick is never asserted. Press btn0 at min=59 -> min=0, hr unchanged.
- sw1=0, press btn0..btn3 -> no change to hr/min/sec/running. sw1=1, press btn3 -> running=0. 10 enb pulses -> time frozen. Press btn3 again -> running=1 and counting resumes.
- sw1=1, btn2 edge coincident with enb at sec=30 -> sec=0 (tick dropped). Simultaneous btn0+btn1 edges -> no change.
- Drop rst_n asynchronously mid-count at 12:34:56 -> outputs go to reset values before the next clk edge. Release -> counting resumes from reset values.

Source files
------------

// File: rtl/hhmmss_counter_pkg.sv
// hhmmss_counter_pkg: time-field limits, widths and run/stop encoding
// shared by the time-of-day counter and the date block.
package hhmmss_counter_pkg;
    localparam int TW = 6;
    localparam logic [TW-1:0] MAX_SEC = 6'd59;
    localparam logic [TW-1:0] MAX_MIN = 6'd59;
    localparam logic [TW-1:0] MAX_HR  = 6'd23;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } run_state_e;

    // Anything at or beyond the limit wraps to zero, so bad loads self-heal.
    function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] v, input logic [TW-1:0] lim);
        return (v >= lim) ? '0 : v + 1'b1;
    endfunction
endpackage

// File: rtl/hhmmss_counter_edge.sv
// hhmmss_counter_edge: rising-edge detector, one-cycle pulse per
// low-to-high transition of a debounced button level.
module hhmmss_counter_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);
    logic prev_q, prev_d;

    always_comb prev_d = in;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;

    assign pulse = in & ~prev_q;
endmodule

// File: rtl/hhmmss_counter.sv
// hhmmss_counter: settable hh:mm:ss time-of-day counter with BCD digits
// and a day-rollover pulse; buttons act only in time-adjust mode (sw1=1).
module hhmmss_counter
    import hhmmss_counter_pkg::*;
#(
    parameter int unsigned RST_HR  = 0,
    parameter int unsigned RST_MIN = 0,
    parameter int unsigned RST_SEC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enb,
    input  logic          sw1,
    input  logic [3:0]    btn,
    output logic [TW-1:0] hr,
    output logic [TW-1:0] min,
    output logic [TW-1:0] sec,
    output logic [3:0]    hh1,
    output logic [3:0]    hh2,
    output logic [3:0]    mi1,
    output logic [3:0]    mi2,
    output logic [3:0]    ss1,
    output logic [3:0]    ss2,
    output logic          day_tick,
    output logic          running
);
    logic [3:0]    btn_edge;
    logic          act;
    logic [TW-1:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic          day_tick_q, day_tick_d;
    run_state_e    state_q, state_d;

    for (genvar i = 0; i < 4; i++) begin : g_edge
        hhmmss_counter_edge u_edge (
            .clk  (clk),
            .rst_n(rst_n),
            .in   (btn[i]),
            .pulse(btn_edge[i])
        );
    end

    assign act = sw1 && $onehot(btn_edge);

    // A valid button action pre-empts the tick; that second is simply lost.
    always_comb begin
        state_d    = state_q;
        hr_d       = hr_q;
        min_d      = min_q;
        sec_d      = sec_q;
        day_tick_d = 1'b0;
        if (act) begin
            if (btn_edge[0]) min_d = wrap_inc(min_q, MAX_MIN);
            if (btn_edge[1]) hr_d = wrap_inc(hr_q, MAX_HR);
            if (btn_edge[2]) sec_d = '0;
            if (btn_edge[3]) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end else if (enb && state_q == ST_RUN) begin
            sec_d = wrap_inc(sec_q, MAX_SEC);
            if (sec_q >= MAX_SEC) begin
                min_d = wrap_inc(min_q, MAX_MIN);
                if (min_q >= MAX_MIN) begin
                    hr_d       = wrap_inc(hr_q, MAX_HR);
                    day_tick_d = hr_q >= MAX_HR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= ST_RUN;
            hr_q       <= TW'(RST_HR);
            min_q      <= TW'(RST_MIN);
            sec_q      <= TW'(RST_SEC);
            day_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            day_tick_q <= day_tick_d;
        end

    assign hr       = hr_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign day_tick = day_tick_q;
    assign running  = state_q == ST_RUN;
    assign hh1      = 4'(hr_q / 6'd10);
    assign hh2      = 4'(hr_q % 6'd10);
    assign mi1      = 4'(min_q / 6'd10);
    assign mi2      = 4'(min_q % 6'd10);
    assign ss1      = 4'(sec_q / 6'd10);
    assign ss2      = 4'(sec_q % 6'd10);
endmodule
